// File: rtl/palette_lut_prog.sv
// Run-time programmable colour palette: index -> {R,G,B} through a writable RAM, two-stage registered lookup.
// Define PALETTE_FADE_EN to build the global brightness fade engine; otherwise brightness is fixed at full scale.
module palette_lut_prog #(
  parameter int INDEX_W  = 4,
  parameter int CH_W     = 4,
  parameter int FADE_DIV = 262144
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                pix_valid_i,
  input  logic [INDEX_W-1:0]  index_i,
  output logic                pix_valid_o,
  output logic [CH_W-1:0]     red,
  output logic [CH_W-1:0]     green,
  output logic [CH_W-1:0]     blue,
  input  logic                wr_en,
  input  logic [INDEX_W-1:0]  wr_addr,
  input  logic [3*CH_W-1:0]   wr_data,
  output logic                init_busy,
  input  logic                fade_start,
  input  logic [CH_W-1:0]     fade_target,
  output logic                fade_busy
);

  localparam int DEPTH = 2 ** INDEX_W;
  localparam int RGB_W = 3 * CH_W;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t             state;
  logic [INDEX_W-1:0] init_addr;
  logic [CH_W-1:0]    init_grey;

  logic               ram_we;
  logic [INDEX_W-1:0] ram_waddr;
  logic [RGB_W-1:0]   ram_wdata;
  logic [RGB_W-1:0]   mem [DEPTH];
  logic [RGB_W-1:0]   rd_data;
  logic               valid_s1;

  logic [CH_W-1:0]    bright;

  // Channel scaling: (c*B + c) >> CH_W keeps full brightness exact and zero brightness black.
  function automatic logic [CH_W-1:0] scale(input logic [CH_W-1:0] c, input logic [CH_W-1:0] b);
    logic [2*CH_W:0] prod;
    prod = ({{(CH_W+1){1'b0}}, c} * {{(CH_W+1){1'b0}}, b}) + {{(CH_W+1){1'b0}}, c};
    return CH_W'(prod >> CH_W);
  endfunction

  assign init_grey = CH_W'(init_addr);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state     <= ST_INIT;
      init_addr <= '0;
      init_busy <= 1'b1;
    end else begin
      case (state)
        ST_INIT: begin
          init_addr <= init_addr + INDEX_W'(1);
          if (init_addr == INDEX_W'(DEPTH - 1)) begin
            state     <= ST_RUN;
            init_busy <= 1'b0;
          end
        end
        ST_RUN:  state <= ST_RUN;
        default: state <= ST_INIT;
      endcase
    end
  end

  // The init sequencer owns the write port until the ramp is complete.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wr_addr;
    ram_wdata = wr_data;
    if (Reset_n) begin
      if (state == ST_INIT) begin
        ram_we    = 1'b1;
        ram_waddr = init_addr;
        ram_wdata = {init_grey, init_grey, init_grey};
      end else if (wr_en) begin
        ram_we = 1'b1;
      end
    end
  end

  // NOTE: the RAM array and its read register carry no reset so they map onto block RAM;
  // the INIT sequence is what gives the contents a defined value.
  always_ff @(posedge Clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    rd_data <= mem[index_i];
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      valid_s1    <= 1'b0;
      pix_valid_o <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
    end else begin
      valid_s1    <= pix_valid_i && (state == ST_RUN);
      pix_valid_o <= valid_s1;
      if (valid_s1) begin
        red   <= scale(rd_data[RGB_W-1:2*CH_W], bright);
        green <= scale(rd_data[2*CH_W-1:CH_W],  bright);
        blue  <= scale(rd_data[CH_W-1:0],       bright);
      end
    end
  end

`ifdef PALETTE_FADE_EN
  localparam int DIV_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

  logic [CH_W-1:0]  target;
  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      bright    <= '1;
      target    <= '1;
      div_cnt   <= '0;
      fade_busy <= 1'b0;
    end else if (fade_start) begin
      target    <= fade_target;
      div_cnt   <= '0;
      fade_busy <= (bright != fade_target);
    end else begin
      fade_busy <= (bright != target);
      if (div_cnt == DIV_W'(FADE_DIV - 1)) begin
        div_cnt <= '0;
        if (bright < target)      bright <= bright + CH_W'(1);
        else if (bright > target) bright <= bright - CH_W'(1);
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end
`else
  logic unused_fade;

  assign bright      = '1;
  assign fade_busy   = 1'b0;
  assign unused_fade = ^{fade_start, fade_target};
`endif

endmodule
